sample_stream_packer: RTL and testbench

Downstream of the clock-domain crosser in the quad ADC path, entirely in the AXI clock domain. Takes each valid 4-channel 14-bit sample, applies optional decimation, sign-extends and packs the four channels into one 64-bit word, and buffers words in a synchronous FIFO. The FIFO drains onto an AXI-Stream master toward the DMA engine. Drops on FIFO overflow are counted, not stalled, because the upstream sample stream cannot be back-pressured.

---
 rtl/sample_stream_packer_pkg.sv | 21 ++
 rtl/sample_stream_packer_if.sv | 31 +++
 rtl/sample_stream_packer_sync_fifo.sv | 57 +++++
 rtl/sample_stream_packer.sv | 137 +++++++++++++
 tb/tb_sample_stream_packer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_stream_packer_pkg.sv
// Shared widths and helpers for the quad-ADC sample packer.
// SAMPLE_STREAM_PACKER_TLAST_EN widens the FIFO word by one bit for the packet-last flag.
package sample_stream_packer_pkg;

   localparam int ADC_WIDTH    = 14;
   localparam int LANE_WIDTH   = 16;
   localparam int NUM_CHANNELS = 4;
   localparam int WORD_WIDTH   = 64;

`ifdef SAMPLE_STREAM_PACKER_TLAST_EN
   localparam int FIFO_WIDTH = WORD_WIDTH + 1;
`else
   localparam int FIFO_WIDTH = WORD_WIDTH;
`endif

   // Replicate the ADC sign bit into the upper bits of a lane.
   function automatic logic [LANE_WIDTH-1:0] sign_ext(input logic [ADC_WIDTH-1:0] s);
      return {{(LANE_WIDTH-ADC_WIDTH){s[ADC_WIDTH-1]}}, s};
   endfunction

endpackage

// File: rtl/sample_stream_packer_if.sv
// AXI-Stream link from the packer toward the DMA engine.
// TLAST exists only when SAMPLE_STREAM_PACKER_TLAST_EN is defined.
interface sample_stream_packer_if;
   import sample_stream_packer_pkg::*;

   logic [WORD_WIDTH-1:0] TDATA;
   logic                  TVALID;
   logic                  TREADY;
`ifdef SAMPLE_STREAM_PACKER_TLAST_EN
   logic                  TLAST;
`endif

   modport master (
      output TDATA,
      output TVALID,
      input  TREADY
`ifdef SAMPLE_STREAM_PACKER_TLAST_EN
      , output TLAST
`endif
   );

   modport slave (
      input  TDATA,
      input  TVALID,
      output TREADY
`ifdef SAMPLE_STREAM_PACKER_TLAST_EN
      , input  TLAST
`endif
   );

endinterface

// File: rtl/sample_stream_packer_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port.
// The caller only pushes when not full (or popping) and only pops when not empty.
// Pointers carry one extra MSB so full and empty are distinguishable.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;

   // Pointer advance on push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // Pointer registers; reset empties the FIFO without touching storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; a full FIFO popping this cycle reuses the head slot.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level_o = wr_ptr_q - rd_ptr_q;
   // Stale storage is hidden while empty so the output reads zero after reset.
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sample_stream_packer.sv
// Decimates, sign-extends and packs 4x14-bit ADC samples into 64-bit words,
// buffers them and streams them out. Overflow drops are counted, never stalled.
// Optional SAMPLE_STREAM_PACKER_TLAST_EN adds packet framing via M_AXIS.TLAST.
module sample_stream_packer
   import sample_stream_packer_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int PACKET_LEN  = 256,
   parameter int DECIM_WIDTH = 8
) (
   input  logic                          AXI_CLK,
   input  logic                          RESET,
   input  logic                          ENABLE,
   input  logic [DECIM_WIDTH-1:0]        DECIMATION,
   input  logic                          AXI_DATA_VALID,
   input  logic [ADC_WIDTH-1:0]          AXI_CH_1_DATA,
   input  logic [ADC_WIDTH-1:0]          AXI_CH_2_DATA,
   input  logic [ADC_WIDTH-1:0]          AXI_CH_3_DATA,
   input  logic [ADC_WIDTH-1:0]          AXI_CH_4_DATA,
   sample_stream_packer_if.master        M_AXIS,
   output logic [15:0]                   OVERFLOW_COUNT,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

   localparam logic [DECIM_WIDTH-1:0] DECIM_ONE = 1;

   if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PACKET_LEN < 1) begin : g_bad_param
      $error("sample_stream_packer: FIFO_DEPTH must be a power of two >= 4, PACKET_LEN >= 1");
   end

   logic [DECIM_WIDTH-1:0] decim_cnt_q, decim_cnt_d;
   logic [15:0]            ovf_q, ovf_d;
   logic                   accept;
   logic                   push, pop, drop;
   logic                   fifo_full, fifo_empty;
   logic [ADC_WIDTH-1:0]   ch [NUM_CHANNELS];
   logic [WORD_WIDTH-1:0]  packed_word;
   logic [FIFO_WIDTH-1:0]  fifo_wdata, fifo_rdata;

   assign ch[0] = AXI_CH_1_DATA;
   assign ch[1] = AXI_CH_2_DATA;
   assign ch[2] = AXI_CH_3_DATA;
   assign ch[3] = AXI_CH_4_DATA;

   // Decimation down-counter: accept at terminal count zero, then reload.
   always_comb begin
      decim_cnt_d = decim_cnt_q;
      accept      = 1'b0;
      if (!ENABLE) begin
         decim_cnt_d = '0;
      end else if (AXI_DATA_VALID) begin
         if (decim_cnt_q == '0) begin
            accept      = 1'b1;
            decim_cnt_d = DECIMATION;
         end else begin
            decim_cnt_d = decim_cnt_q - DECIM_ONE;
         end
      end
   end

   // Lane packing, CH1 in the least significant lane.
   always_comb begin
      packed_word = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         packed_word[i*LANE_WIDTH +: LANE_WIDTH] = sign_ext(ch[i]);
      end
   end

   assign pop  = M_AXIS.TVALID && M_AXIS.TREADY;
   assign push = accept && (!fifo_full || pop);
   assign drop = accept && fifo_full && !pop;

   // Saturating drop counter.
   always_comb begin
      ovf_d = ovf_q;
      if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
   end

   // Decimation and overflow state.
   always_ff @(posedge AXI_CLK) begin
      if (RESET) begin
         decim_cnt_q <= '0;
         ovf_q       <= '0;
      end else begin
         decim_cnt_q <= decim_cnt_d;
         ovf_q       <= ovf_d;
      end
   end

`ifdef SAMPLE_STREAM_PACKER_TLAST_EN
   localparam int PW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
   localparam logic [PW-1:0] PKT_ONE  = 1;
   localparam logic [PW-1:0] PKT_LAST = PW'(PACKET_LEN - 1);

   logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic          pkt_last;

   // Packet counter advances only on words actually written, so a disable
   // or a drop never shortens a packet.
   always_comb begin
      pkt_last  = (pkt_cnt_q == PKT_LAST);
      pkt_cnt_d = pkt_cnt_q;
      if (push) pkt_cnt_d = pkt_last ? '0 : pkt_cnt_q + PKT_ONE;
   end

   // Packet counter register.
   always_ff @(posedge AXI_CLK) begin
      if (RESET) pkt_cnt_q <= '0;
      else       pkt_cnt_q <= pkt_cnt_d;
   end

   assign fifo_wdata   = {pkt_last, packed_word};
   assign M_AXIS.TLAST = fifo_rdata[WORD_WIDTH];
`else
   assign fifo_wdata   = packed_word;
`endif

   sync_fifo #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (AXI_CLK),
      .rst     (RESET),
      .push_i  (push),
      .wdata_i (fifo_wdata),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (FIFO_LEVEL)
   );

   assign M_AXIS.TDATA   = fifo_rdata[WORD_WIDTH-1:0];
   assign M_AXIS.TVALID  = !fifo_empty;
   assign OVERFLOW_COUNT = ovf_q;

endmodule

// File: tb/tb_sample_stream_packer.sv
// Bench for sample_stream_packer: directed cases plus randomized traffic,
// all checked against a queue-based reference model.
module tb_sample_stream_packer;
   import sample_stream_packer_pkg::*;

   localparam int DEPTH = 16;
   localparam int PLEN  = 4;
   localparam int DW    = 8;

   logic          clk = 1'b0;
   logic          rst, en, valid;
   logic [DW-1:0] decim;
   logic [13:0]   ch1, ch2, ch3, ch4;
   logic [15:0]   ovf;
   logic [4:0]    level;

   always #5 clk = ~clk;

   sample_stream_packer_if axis();

   sample_stream_packer #(
      .FIFO_DEPTH  (DEPTH),
      .PACKET_LEN  (PLEN),
      .DECIM_WIDTH (DW)
   ) dut (
      .AXI_CLK        (clk),
      .RESET          (rst),
      .ENABLE         (en),
      .DECIMATION     (decim),
      .AXI_DATA_VALID (valid),
      .AXI_CH_1_DATA  (ch1),
      .AXI_CH_2_DATA  (ch2),
      .AXI_CH_3_DATA  (ch3),
      .AXI_CH_4_DATA  (ch4),
      .M_AXIS         (axis),
      .OVERFLOW_COUNT (ovf),
      .FIFO_LEVEL     (level)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model state.
   logic [64:0] mq[$];
   logic [63:0] pop_log[$];
   bit          last_log[$];
   int          m_ovf     = 0;
   int          m_words   = 0;
   bit          m_first   = 1;
   int          m_skipped = 0;
   int          m_dlast   = 0;

   function automatic logic [15:0] lane_ref(input logic [13:0] x);
      int v;
      v = int'(x);
      if (v >= 8192) v = v - 16384;
      return 16'(v);
   endfunction

   function automatic logic [63:0] pack_ref(input logic [13:0] a, b, c, d);
      return {lane_ref(d), lane_ref(c), lane_ref(b), lane_ref(a)};
   endfunction

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic step(input bit v, input bit rdy,
                       input logic [13:0] a, input logic [13:0] b,
                       input logic [13:0] c, input logic [13:0] d);
      bit pop;
      bit acc;
      bit last;
      valid       = v;
      axis.TREADY = rdy;
      ch1 = a; ch2 = b; ch3 = c; ch4 = d;
      pop = (mq.size() > 0) && rdy;
      acc = 0;
      last = 0;
      if (!rst && axis.TVALID === 1'b1 && rdy) begin
         pop_log.push_back(axis.TDATA);
`ifdef SAMPLE_STREAM_PACKER_TLAST_EN
         last_log.push_back(axis.TLAST);
`endif
      end
      if (rst) begin
         mq.delete();
         m_ovf = 0; m_words = 0; m_first = 1; m_skipped = 0;
      end else begin
         if (!en) begin
            m_first = 1;
         end else if (v) begin
            if (m_first || m_skipped == m_dlast) begin
               acc = 1; m_first = 0; m_skipped = 0; m_dlast = int'(decim);
            end else begin
               m_skipped++;
            end
         end
         if (pop) void'(mq.pop_front());
         if (acc) begin
            if (mq.size() < DEPTH) begin
`ifdef SAMPLE_STREAM_PACKER_TLAST_EN
               last = ((m_words % PLEN) == PLEN - 1);
`endif
               m_words++;
               mq.push_back({last, pack_ref(a, b, c, d)});
            end else if (m_ovf < 65535) begin
               m_ovf++;
            end
         end
      end
      @(posedge clk);
      #1;
      check("tvalid", 65'(axis.TVALID), 65'(mq.size() > 0));
      check("level", 65'(level), 65'(mq.size()));
      check("ovf", 65'(ovf), 65'(m_ovf));
      if (mq.size() > 0) begin
         check("tdata", 65'(axis.TDATA), 65'(mq[0][63:0]));
`ifdef SAMPLE_STREAM_PACKER_TLAST_EN
         check("tlast", 65'(axis.TLAST), 65'(mq[0][64]));
`endif
      end
   endtask

   task automatic rand_sample(input bit rdy);
      step(1, rdy, 14'($urandom), 14'($urandom), 14'($urandom), 14'($urandom));
   endtask

   task automatic idle(input bit rdy);
      step(0, rdy, '0, '0, '0, '0);
   endtask

   initial begin
      logic [63:0] first_word;
      logic [13:0] s1, s2, s3, s4;
      rst = 1; en = 0; valid = 0; decim = '0;
      ch1 = '0; ch2 = '0; ch3 = '0; ch4 = '0;
      axis.TREADY = 1'b0;
      idle(0);
      idle(0);
      rst = 0;
      check("rst_tdata", 65'(axis.TDATA), 65'(0));
`ifdef SAMPLE_STREAM_PACKER_TLAST_EN
      check("rst_tlast", 65'(axis.TLAST), 65'(0));
`endif

      // Packing with sign extension.
      en = 1; decim = 0;
      step(1, 1, 14'h0A00, 14'h0B00, 14'h3C00, 14'h2001);
      check("pack_word", 65'(axis.TDATA), 65'(64'hE001_FC00_0B00_0A00));
      idle(1);
      idle(1);

      // Decimation by 4.
      decim = 3;
      pop_log.delete();
      for (int i = 0; i < 12; i++) step(1, 1, 14'(i), 14'h1234, 14'h2345, 14'h0345);
      idle(1);
      idle(1);
      check("decim_count", 65'(pop_log.size()), 65'(3));
      if (pop_log.size() == 3)
         for (int k = 0; k < 3; k++) check("decim_ch1", 65'(pop_log[k][15:0]), 65'(k * 4));

      // Overflow with downstream stalled.
      decim = 0; en = 0;
      idle(1);
      en = 1;
      pop_log.delete();
      s1 = 14'($urandom); s2 = 14'($urandom); s3 = 14'($urandom); s4 = 14'($urandom);
      first_word = {lane_ref(s4), lane_ref(s3), lane_ref(s2), lane_ref(s1)};
      step(1, 0, s1, s2, s3, s4);
      for (int i = 0; i < DEPTH + 4; i++) rand_sample(0);
      check("ovf_level", 65'(level), 65'(16));
      check("ovf_count", 65'(ovf), 65'(5));
      check("ovf_head", 65'(axis.TDATA), 65'(first_word));
      // Full FIFO, pop and new sample together.
      rand_sample(1);
      check("fullpop_level", 65'(level), 65'(16));
      check("fullpop_ovf", 65'(ovf), 65'(5));
      for (int i = 0; i < DEPTH; i++) idle(1);
      check("drain_count", 65'(pop_log.size()), 65'(17));
      if (pop_log.size() > 0) check("drain_first", 65'(pop_log[0]), 65'(first_word));
      check("drain_empty", 65'(level), 65'(0));

`ifdef SAMPLE_STREAM_PACKER_TLAST_EN
      // Packet framing across a disable.
      rst = 1; idle(1); rst = 0;
      en = 1; decim = 0;
      pop_log.delete(); last_log.delete();
      for (int i = 0; i < 6; i++) rand_sample(1);
      en = 0;
      rand_sample(1);
      rand_sample(1);
      en = 1;
      for (int i = 0; i < 4; i++) rand_sample(1);
      idle(1); idle(1);
      check("tlast_words", 65'(last_log.size()), 65'(10));
      if (last_log.size() == 10)
         for (int k = 0; k < 10; k++) check("tlast_flag", 65'(last_log[k]), 65'(k == 3 || k == 7));
`endif

      // Randomized traffic with decimation changes and enable toggles.
      for (int seg = 0; seg < 8; seg++) begin
         int rdy_pct;
         rdy_pct = int'($urandom_range(20, 100));
         en = 0;
         idle(1);
         decim = DW'($urandom_range(0, 3));
         en = 1;
         for (int i = 0; i < 50; i++) begin
            bit v, r;
            v = ($urandom_range(0, 99) < 70);
            r = ($urandom_range(0, 99) < rdy_pct);
            if ($urandom_range(0, 19) == 0) decim = DW'($urandom_range(0, 3));
            step(v, r, 14'($urandom), 14'($urandom), 14'($urandom), 14'($urandom));
         end
      end

      // Reset mid-stream with words buffered and drops counted.
      en = 0; idle(1);
      en = 1; decim = 0;
      for (int i = 0; i < DEPTH + 3; i++) rand_sample(0);
      while (level > 7 && n_tests < 100000) idle(1);
      check("pre_rst_level", 65'(level), 65'(7));
      rst = 1;
      rand_sample(1);
      rst = 0;
      check("rst_tvalid", 65'(axis.TVALID), 65'(0));
      check("rst_level", 65'(level), 65'(0));
      check("rst_ovf", 65'(ovf), 65'(0));
      idle(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
